// File: rtl/regfile_pkg.sv
// Shared register-file parameters and the dump FSM state type.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;
endpackage

// File: rtl/reg_dump_unit.sv
// Streams a contiguous register range out of a register-file read port,
// one word per LOAD/SEND pair, with abort and range-rejection support.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data, out_addr and out_last hold stable. out_valid never drops
// without a transfer except on abort or reset.
module reg_dump_unit
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output dump_state_e       dbg_state
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            cur_d   = first_reg;
            last_d  = last_reg;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          out_data_d  = rd_data;
          out_addr_d  = cur_q;
          out_last_d  = (cur_q == last_q);
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        // Abort wins over a handshake landing on the same edge.
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_addr   = cur_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed-plus-random bench for reg_dump_unit against a queue-based model
// of the expected word stream.
module tb_reg_dump_unit;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_reg = '0;
  logic [ADDR_W-1:0] last_reg = '0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;
  dump_state_e       dbg_state;

  logic [DATA_W-1:0] regs [32];
  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  reg_dump_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_addr"},  out_addr, 0);
    chk({tag, "_rdaddr"}, rd_addr, 0);
  endtask

  // Runs one accepted dump; stall<0 means a random 0..3 stall per word.
  task automatic do_dump(input int f, input int l, input int stall, input bit repulse);
    logic [37:0] exp_q[$];
    logic [37:0] held;
    logic [37:0] cur_word;
    int obs, first_valid_obs, stall_cnt, n_words, n_hs;
    bit new_word, prev_hs, got_done;

    for (int a = f; a <= l; a++) exp_q.push_back({(a == l), a[4:0], regs[a]});
    n_words = exp_q.size();
    first_reg = f[4:0];
    last_reg = l[4:0];
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    obs = 1; new_word = 1; prev_hs = 0; got_done = 0;
    first_valid_obs = 0; stall_cnt = 0; n_hs = 0; held = '0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        chk("done_after_last_hs", prev_hs, 1);
        chk("done_queue_empty", exp_q.size(), 0);
        chk("err_on_good_range", err, 0);
        chk("handshake_count", n_hs, n_words);
        if (stall == 0) chk("done_latency", obs, 2 * n_words + 1);
        got_done = 1;
        break;
      end
      prev_hs = 0;
      cur_word = {out_last, out_addr, out_data};
      if (out_valid) begin
        if (first_valid_obs == 0) first_valid_obs = obs;
        if (new_word) begin
          if (exp_q.size() == 0) chk("extra_word", 1, 0);
          else chk("word", cur_word, exp_q[0]);
          held = cur_word;
          new_word = 0;
          stall_cnt = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end else begin
          chk("stable_while_stalled", cur_word, held);
        end
        out_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          new_word = 1;
          prev_hs = 1;
          n_hs++;
        end
        if (repulse && exp_q.size() > 0) begin
          start = 1'($urandom_range(0, 1));
          first_reg = 5'd10;
          last_reg = 5'd12;
        end else begin
          start = 1'b0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      obs++;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("first_valid_latency", first_valid_obs, 2);
    if (got_done) begin
      tick();
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("no_valid_after_done", out_valid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = i * 4;

    // reset state
    #3;
    chk_all_zero("reset");
    chk("reset_state", dbg_state, ST_IDLE);
    tick();
    rstn = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // abort ignored in IDLE
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);

    // full dump 0..31 with ready high
    do_dump(0, 31, 0, 0);

    // backpressure 3..5
    do_dump(3, 5, 3, 0);

    // rejected range
    first_reg = 5'd9; last_reg = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("reject_done", done, 1);
    chk("reject_err", err, 1);
    chk("reject_valid", out_valid, 0);
    tick();
    chk("reject_done_clear", done, 0);
    chk("reject_err_clear", err, 0);
    chk("reject_busy_clear", busy, 0);
    chk("reject_no_valid", out_valid, 0);

    // abort during SEND of word 2, colliding with a handshake
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    first_reg = 5'd0; last_reg = 5'd7; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    begin
      bit reached;
      reached = 0;
      for (int c = 0; c < 50; c++) begin
        if (out_valid && out_addr == 5'd2) begin
          reached = 1;
          break;
        end
        out_ready = out_valid;
        tick();
      end
      chk("abort_reached_word2", reached, 1);
    end
    chk("abort_word2_data", out_data, regs[2]);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    do_dump(0, 7, 0, 0);

    // single register 31, including register 0 range checks via random dumps
    do_dump(31, 31, 0, 0);
    do_dump(0, 0, -1, 0);

    // reset asserted in LOAD
    first_reg = 5'd31; last_reg = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_reset_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset_state", dbg_state, ST_IDLE);
    tick();
    chk("reset_hold_done", done, 0);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_reset_no_done", done, 0);
      chk("post_reset_idle", busy, 0);
    end

    // start re-pulsed while busy
    do_dump(0, 3, 0, 1);

    // random ranges and random stalls
    for (int t = 0; t < 6; t++) begin
      int f, l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      do_dump(f, l, -1, (t % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
